// File: rtl/osd_uart16550_pkg.sv
// Shared constants for the 16550-style UART register file on the NASTI-lite bus:
// register offsets, LSR/IER/FCR bit positions, IIR codes and the fixed MSR value.
package osd_uart16550_pkg;

  localparam logic [2:0] ADDR_RBR = 3'd0;
  localparam logic [2:0] ADDR_IER = 3'd1;
  localparam logic [2:0] ADDR_IIR = 3'd2;
  localparam logic [2:0] ADDR_LCR = 3'd3;
  localparam logic [2:0] ADDR_MCR = 3'd4;
  localparam logic [2:0] ADDR_LSR = 3'd5;
  localparam logic [2:0] ADDR_MSR = 3'd6;
  localparam logic [2:0] ADDR_SCR = 3'd7;

  localparam int LSR_DR       = 0;
  localparam int LSR_THRE     = 5;
  localparam int LSR_TEMT     = 6;
  localparam int LCR_DLAB     = 7;
  localparam int IER_RDA      = 0;
  localparam int IER_THRE     = 1;
  localparam int FCR_RX_FLUSH = 1;
  localparam int FCR_TX_FLUSH = 2;

  localparam logic [7:0] IIR_RDA     = 8'h04;
  localparam logic [7:0] IIR_THRE    = 8'h02;
  localparam logic [7:0] IIR_NONE    = 8'h01;
  localparam logic [7:0] MSR_DEFAULT = 8'hB0;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_e;

endpackage

// File: rtl/osd_uart_byte_fifo.sv
// Byte FIFO with one extra pointer bit so full and empty are distinguishable.
// A pop frees a slot in the same cycle, so push+pop on a full FIFO is accepted.
// Flush empties the FIFO and takes priority over a concurrent push.
module osd_uart_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [7:0]                 head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer update: flush resets both pointers, otherwise advance on push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/osd_uart16550_nasti_slave.sv
// 16550-compatible register file answering on the 8-bit NASTI-lite bus.
// THR writes feed the TX FIFO toward the debug transport; transport bytes land
// in the RX FIFO and are read through RBR. Divisor latches are storage only.
module osd_uart16550_nasti_slave
  import osd_uart16550_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] aw_addr,
  input  logic       aw_valid,
  output logic       aw_ready,
  input  logic [7:0] w_data,
  input  logic       w_valid,
  output logic       w_ready,
  output logic [1:0] b_resp,
  output logic       b_valid,
  input  logic       b_ready,
  input  logic [2:0] ar_addr,
  input  logic       ar_valid,
  output logic       ar_ready,
  output logic [7:0] r_data,
  output logic [1:0] r_resp,
  output logic       r_valid,
  input  logic       r_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       irq
);

  wr_state_e wr_state, wr_next;

  logic [7:0] ier, lcr, mcr, scr, dll, dlm;
  logic       thre_ack;
  logic       dlab, thr_target, wr_fire, rd_fire;
  logic       tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic       rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic       dr, thre, temt;
  logic [7:0] lsr, iir, rd_mux;

  assign dlab       = lcr[LCR_DLAB];
  assign thr_target = (aw_addr == ADDR_RBR) && !dlab;
  assign wr_fire    = aw_valid && w_valid && (wr_state == WR_IDLE) && !(thr_target && tx_full);
  assign aw_ready   = wr_fire;
  assign w_ready    = wr_fire;
  assign b_resp     = 2'b00;
  assign r_resp     = 2'b00;

  assign ar_ready = !r_valid;
  assign rd_fire  = ar_valid && ar_ready;

  assign tx_push  = wr_fire && thr_target;
  assign tx_flush = wr_fire && (aw_addr == ADDR_IIR) && w_data[FCR_TX_FLUSH];
  assign rx_flush = wr_fire && (aw_addr == ADDR_IIR) && w_data[FCR_RX_FLUSH];
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_head;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rd_fire && (ar_addr == ADDR_RBR) && !dlab && !rx_empty;

  assign dr   = (rx_count != '0);
  assign thre = (tx_count == '0);
  assign temt = thre && !tx_valid;

  osd_uart_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .push_data(w_data), .pop(tx_pop),
    .flush(tx_flush), .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  osd_uart_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .push_data(rx_data), .pop(rx_pop),
    .flush(rx_flush), .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // Status and interrupt identification derived from FIFO levels and IER.
  always_comb begin
    lsr = 8'h00;
    lsr[LSR_DR]   = dr;
    lsr[LSR_THRE] = thre;
    lsr[LSR_TEMT] = temt;
    iir = IIR_NONE;
    if (ier[IER_RDA] && dr)                     iir = IIR_RDA;
    else if (ier[IER_THRE] && thre && !thre_ack) iir = IIR_THRE;
  end

  assign irq = !iir[0];

  // Read data selection; always reflects state before any same-cycle write.
  always_comb begin
    rd_mux = 8'h00;
    case (ar_addr)
      ADDR_RBR: rd_mux = dlab ? dll : (rx_empty ? 8'h00 : rx_head);
      ADDR_IER: rd_mux = dlab ? dlm : ier;
      ADDR_IIR: rd_mux = iir;
      ADDR_LCR: rd_mux = lcr;
      ADDR_MCR: rd_mux = mcr;
      ADDR_LSR: rd_mux = lsr;
      ADDR_MSR: rd_mux = MSR_DEFAULT;
      ADDR_SCR: rd_mux = scr;
      default:  rd_mux = 8'h00;
    endcase
  end

  // Write-response state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_state <= WR_IDLE;
    else        wr_state <= wr_next;
  end

  // Write-response next state: one write outstanding until b_ready.
  always_comb begin
    wr_next = wr_state;
    b_valid = 1'b0;
    case (wr_state)
      WR_IDLE: if (wr_fire) wr_next = WR_RESP;
      WR_RESP: begin
        b_valid = 1'b1;
        if (b_ready) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  // Register file writes for the accepted write beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ier <= 8'h00; lcr <= 8'h00; mcr <= 8'h00;
      scr <= 8'h00; dll <= 8'h00; dlm <= 8'h00;
    end else if (wr_fire) begin
      case (aw_addr)
        ADDR_RBR: if (dlab) dll <= w_data;
        ADDR_IER: if (dlab) dlm <= w_data; else ier <= w_data;
        ADDR_LCR: lcr <= w_data;
        ADDR_MCR: mcr <= w_data;
        ADDR_SCR: scr <= w_data;
        default:  ;
      endcase
    end
  end

  // THRE interrupt acknowledge: set by reading IIR=THRE, cleared by a new THR write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                  thre_ack <= 1'b0;
    else if (tx_push)                                            thre_ack <= 1'b0;
    else if (rd_fire && (ar_addr == ADDR_IIR) && (iir == IIR_THRE)) thre_ack <= 1'b1;
  end

  // Registered read response held until the master takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= 8'h00;
    end else if (rd_fire) begin
      r_valid <= 1'b1;
      r_data  <= rd_mux;
    end else if (r_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_osd_uart16550_nasti_slave.sv
// Self-checking bench: register table vectors, directed multi-cycle sequences,
// and a randomized run scored against a queue-based model of the UART.
module tb_osd_uart16550_nasti_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] aw_addr = '0;
  logic       aw_valid = 1'b0, aw_ready;
  logic [7:0] w_data = '0;
  logic       w_valid = 1'b0, w_ready;
  logic [1:0] b_resp;
  logic       b_valid, b_ready = 1'b0;
  logic [2:0] ar_addr = '0;
  logic       ar_valid = 1'b0, ar_ready;
  logic [7:0] r_data;
  logic [1:0] r_resp;
  logic       r_valid, r_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0, rx_ready;
  logic       irq;

  int total = 0;
  int bad = 0;
  logic [7:0] tx_got[$];

  always #5 clk = ~clk;

  osd_uart16550_nasti_slave #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .irq(irq)
  );

  // Capture every byte handed to the transport.
  always @(posedge clk) begin
    if (rst_n && tx_valid && tx_ready) tx_got.push_back(tx_data);
  end

  typedef struct {
    bit         wr;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timeout waiting on DUT", name);
  endtask

  task automatic finishWrite();
    int n;
    @(posedge clk); #1;
    aw_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (b_valid) break;
      n++;
      if (n > 50) begin timeoutFail("b_valid"); break; end
    end
    checkOutput("b_resp", {6'b0, b_resp}, 8'h00);
    @(posedge clk); #1;
    b_ready = 1'b0;
  endtask

  task automatic busWrite(input logic [2:0] a, input logic [7:0] d);
    int n;
    @(posedge clk); #1;
    aw_addr = a; w_data = d; aw_valid = 1'b1; w_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (aw_ready && w_ready) break;
      n++;
      if (n > 200) begin timeoutFail("aw_ready"); break; end
    end
    finishWrite();
  endtask

  task automatic busRead(input logic [2:0] a, output logic [7:0] d);
    int n;
    @(posedge clk); #1;
    ar_addr = a; ar_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (ar_ready) break;
      n++;
      if (n > 50) begin timeoutFail("ar_ready"); break; end
    end
    @(posedge clk); #1;
    ar_valid = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (r_valid) break;
      n++;
      if (n > 50) begin timeoutFail("r_valid"); break; end
    end
    d = r_data;
    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
  endtask

  task automatic sendRx(input logic [7:0] b);
    int n;
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
      if (n > 50) begin timeoutFail("rx_ready"); break; end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    aw_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b0; ar_valid = 1'b0;
    r_ready = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tx_got.delete();
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [7:0] d;
    if (v.wr) busWrite(v.addr, v.data);
    else begin
      busRead(v.addr, d);
      checkOutput(v.name, d, v.exp);
    end
  endtask

  function automatic void addVec(input bit wr, input logic [2:0] a, input logic [7:0] d,
                                 input logic [7:0] e, input string nm);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endfunction

  // Reference model state for the randomized run.
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic [7:0] m_ier;
  bit         m_ack;

  function automatic logic [7:0] modelIir();
    if (m_ier[0] && m_rx.size() != 0) return 8'h04;
    if (m_ier[1] && m_tx.size() == 0 && !m_ack) return 8'h02;
    return 8'h01;
  endfunction

  initial begin
    logic [7:0] d, e, b;
    string msg;
    int op;

    // Register map vectors from reset.
    addVec(0, 3'd5, 8'h00, 8'h60, "lsr_reset");
    addVec(0, 3'd2, 8'h00, 8'h01, "iir_reset");
    addVec(0, 3'd6, 8'h00, 8'hB0, "msr");
    addVec(0, 3'd3, 8'h00, 8'h00, "lcr_reset");
    addVec(1, 3'd7, 8'hA5, 8'h00, "");
    addVec(0, 3'd7, 8'h00, 8'hA5, "scr");
    addVec(1, 3'd4, 8'h1F, 8'h00, "");
    addVec(0, 3'd4, 8'h00, 8'h1F, "mcr");
    addVec(1, 3'd3, 8'h80, 8'h00, "");
    addVec(1, 3'd0, 8'hDE, 8'h00, "");
    addVec(1, 3'd1, 8'hAD, 8'h00, "");
    addVec(1, 3'd3, 8'h00, 8'h00, "");
    addVec(0, 3'd0, 8'h00, 8'h00, "rbr_empty");
    addVec(0, 3'd1, 8'h00, 8'h00, "ier_dlab0");
    addVec(1, 3'd3, 8'h80, 8'h00, "");
    addVec(0, 3'd0, 8'h00, 8'hDE, "dll");
    addVec(0, 3'd1, 8'h00, 8'hAD, "dlm");
    addVec(0, 3'd3, 8'h00, 8'h80, "lcr_dlab");
    addVec(1, 3'd3, 8'h00, 8'h00, "");
    addVec(1, 3'd5, 8'hFF, 8'h00, "");
    addVec(0, 3'd5, 8'h00, 8'h60, "lsr_ro");
    addVec(1, 3'd1, 8'h02, 8'h00, "");
    addVec(0, 3'd2, 8'h00, 8'h02, "iir_thre");
    addVec(0, 3'd2, 8'h00, 8'h01, "iir_thre_ack");
    addVec(1, 3'd1, 8'h00, 8'h00, "");

    doReset();
    checkOutput("rst_b_valid", {7'b0, b_valid}, 8'h00);
    checkOutput("rst_r_valid", {7'b0, r_valid}, 8'h00);
    checkOutput("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    checkOutput("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    checkOutput("rst_irq", {7'b0, irq}, 8'h00);
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Single THR byte goes out exactly once.
    doReset();
    tx_ready = 1'b1;
    busWrite(3'd0, 8'h48);
    repeat (5) @(posedge clk);
    checkOutput("tx_once_cnt", tx_got.size(), 8'd1);
    if (tx_got.size() > 0) checkOutput("tx_once_data", tx_got[0], 8'h48);

    // Message buffered while the transport is stalled.
    doReset();
    msg = "Hello World!\n";
    for (int i = 0; i < msg.len(); i++) busWrite(3'd0, msg[i]);
    repeat (3) @(posedge clk);
    checkOutput("hello_held", tx_got.size(), 8'd0);
    busRead(3'd5, d);
    checkOutput("lsr_tx_busy", d, 8'h00);
    tx_ready = 1'b1;
    repeat (20) @(posedge clk);
    checkOutput("hello_cnt", tx_got.size(), 8'd13);
    for (int i = 0; i < 13 && i < tx_got.size(); i++) checkOutput("hello_byte", tx_got[i], msg[i]);

    // Full TX FIFO stalls the next THR write until one byte leaves.
    doReset();
    for (int i = 0; i < 16; i++) busWrite(3'd0, 8'h10 + 8'(i));
    @(posedge clk); #1;
    aw_addr = 3'd0; w_data = 8'hEE; aw_valid = 1'b1; w_valid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("stall_w_ready", {7'b0, w_ready}, 8'h00);
    checkOutput("stall_rx_ready_ok", {7'b0, rx_ready}, 8'h01);
    @(posedge clk); #1; tx_ready = 1'b1;
    @(posedge clk); #1; tx_ready = 1'b0;
    @(negedge clk);
    checkOutput("stall_release", {7'b0, w_ready}, 8'h01);
    finishWrite();
    tx_ready = 1'b1;
    repeat (25) @(posedge clk);
    checkOutput("stall_cnt", tx_got.size(), 8'd17);
    if (tx_got.size() == 17) begin
      checkOutput("stall_first", tx_got[0], 8'h10);
      checkOutput("stall_last", tx_got[16], 8'hEE);
    end

    // Received byte raises the data-ready interrupt until RBR is read.
    doReset();
    sendRx(8'h5A);
    busWrite(3'd1, 8'h01);
    @(negedge clk);
    checkOutput("rx_irq", {7'b0, irq}, 8'h01);
    busRead(3'd2, d); checkOutput("rx_iir", d, 8'h04);
    busRead(3'd5, d); checkOutput("rx_lsr", d, 8'h61);
    busRead(3'd0, d); checkOutput("rx_rbr", d, 8'h5A);
    @(negedge clk);
    checkOutput("rx_irq_clr", {7'b0, irq}, 8'h00);
    busRead(3'd5, d); checkOutput("rx_lsr_clr", d, 8'h60);

    // Reset in the middle of an outstanding write with TX data queued.
    doReset();
    for (int i = 0; i < 3; i++) busWrite(3'd0, 8'h30 + 8'(i));
    @(posedge clk); #1;
    aw_addr = 3'd7; w_data = 8'h77; aw_valid = 1'b1; w_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    aw_valid = 1'b0; w_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_b_valid", {7'b0, b_valid}, 8'h01);
    checkOutput("mid_tx_valid", {7'b0, tx_valid}, 8'h01);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_b_valid", {7'b0, b_valid}, 8'h00);
    checkOutput("mid_rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    busRead(3'd5, d); checkOutput("mid_lsr", d, 8'h60);
    busRead(3'd7, d); checkOutput("mid_scr", d, 8'h00);

    // Randomized traffic against the queue model, transport stalled.
    doReset();
    m_tx.delete(); m_rx.delete(); m_ier = 8'h00; m_ack = 1'b0;
    for (int it = 0; it < 250; it++) begin
      op = $urandom_range(0, 7);
      case (op)
        0: if (m_tx.size() < 16) begin
             b = 8'($urandom);
             busWrite(3'd0, b);
             m_tx.push_back(b);
             m_ack = 1'b0;
           end
        1: if (m_rx.size() < 16) begin
             b = 8'($urandom);
             sendRx(b);
             m_rx.push_back(b);
           end
        2: begin
             busRead(3'd0, d);
             e = (m_rx.size() != 0) ? m_rx.pop_front() : 8'h00;
             checkOutput("rnd_rbr", d, e);
           end
        3: begin
             busRead(3'd5, d);
             e = {1'b0, m_tx.size() == 0, m_tx.size() == 0, 4'b0, m_rx.size() != 0};
             checkOutput("rnd_lsr", d, e);
           end
        4: begin
             busRead(3'd2, d);
             e = modelIir();
             if (e == 8'h02) m_ack = 1'b1;
             checkOutput("rnd_iir", d, e);
           end
        5: begin
             m_ier = 8'($urandom_range(0, 3));
             busWrite(3'd1, m_ier);
           end
        6: begin
             b = 8'($urandom);
             busWrite(3'd7, b);
             busRead(3'd7, d);
             checkOutput("rnd_scr", d, b);
           end
        default: if ($urandom_range(0, 3) == 0) begin
             b = 8'($urandom);
             busWrite(3'd2, b);
             if (b[1]) m_rx.delete();
             if (b[2]) m_tx.delete();
           end
      endcase
      @(negedge clk);
      checkOutput("rnd_irq", {7'b0, irq}, {7'b0, modelIir() != 8'h01});
    end
    tx_ready = 1'b1;
    repeat (25) @(posedge clk);
    checkOutput("rnd_tx_cnt", tx_got.size(), m_tx.size());
    for (int i = 0; i < m_tx.size() && i < tx_got.size(); i++)
      checkOutput("rnd_tx_byte", tx_got[i], m_tx[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
